// File: rtl/fe_io_shell.sv
// I/O shell around the frequency-estimator core: input retiming with optional
// lane reversal, drained configuration hand-over, result FIFO and latency watchdog.
module fe_io_shell #(
  parameter int NBW_IN        = 9,
  parameter int FE_NS_IN      = 64,
  parameter int FE_NS_FIR     = 5,
  parameter int NBW_OUT       = NBW_IN + 6,
  parameter int LAT_W         = 10,
  parameter int IN_STAGES     = 1,
  parameter int OUT_DEPTH     = 4,
  parameter int TO_MARGIN     = 16,
  parameter int REVERSE_LANES = 0
) (
  input  logic                          clk,
  input  logic                          rst_async_n,
  input  logic                          i_valid,
  input  logic                          i_enable,
  input  logic [FE_NS_IN*NBW_IN-1:0]    i_data_i,
  input  logic [FE_NS_IN*NBW_IN-1:0]    i_data_q,
  input  logic                          i_cfg_update,
  input  logic                          i_subsampling,
  input  logic [LAT_W-1:0]              i_static_pipe_lat,
  input  logic [FE_NS_FIR*NBW_IN-1:0]   i_static_coef,
  input  logic                          i_status_clr,
  output logic                          o_core_valid,
  output logic                          o_core_enable,
  output logic [FE_NS_IN*NBW_IN-1:0]    o_core_data_i,
  output logic [FE_NS_IN*NBW_IN-1:0]    o_core_data_q,
  output logic                          o_core_subsampling,
  output logic [LAT_W-1:0]              o_core_static_pipe_lat,
  output logic [FE_NS_FIR*NBW_IN-1:0]   o_core_static_coef,
  input  logic                          i_core_fo_valid,
  input  logic [NBW_OUT-1:0]            i_core_fo_value,
  output logic                          o_fo_valid,
  output logic [NBW_OUT-1:0]            o_fo_value,
  input  logic                          i_fo_ready,
  output logic                          o_cfg_busy,
  output logic                          o_drop,
  output logic                          o_overflow,
  output logic                          o_timeout,
  output logic [$clog2(OUT_DEPTH):0]    o_fifo_level
);
  localparam int DW   = FE_NS_IN * NBW_IN;
  localparam int CW   = FE_NS_FIR * NBW_IN;
  localparam int AW   = $clog2(OUT_DEPTH);
  localparam int WD_W = LAT_W + 2;
  localparam logic [LAT_W-1:0] LAT_ONE = 1;
  localparam logic [AW:0]      PTR_ONE = 1;
  localparam logic [WD_W-1:0]  WD_ONE  = 1;

  typedef enum logic [1:0] {IDLE = 2'd0, DRAIN = 2'd1, APPLY = 2'd2} state_t;
  state_t state, state_nxt;

  logic [DW-1:0] lane_i, lane_q;

  generate
    if (REVERSE_LANES != 0) begin : g_rev
      for (genvar k = 0; k < FE_NS_IN; k++) begin : g_lane
        assign lane_i[k*NBW_IN +: NBW_IN] = i_data_i[(FE_NS_IN-1-k)*NBW_IN +: NBW_IN];
        assign lane_q[k*NBW_IN +: NBW_IN] = i_data_q[(FE_NS_IN-1-k)*NBW_IN +: NBW_IN];
      end
    end else begin : g_fwd
      assign lane_i = i_data_i;
      assign lane_q = i_data_q;
    end
  endgenerate

  // Input pipeline: blocks are refused while the core is draining for a config change
  logic valid_in, drop_evt;
  assign valid_in = i_valid && (state != DRAIN);
  assign drop_evt = i_valid && (state == DRAIN);

  logic [IN_STAGES-1:0] vld_p, en_p;
  logic [DW-1:0]        data_i_p [IN_STAGES];
  logic [DW-1:0]        data_q_p [IN_STAGES];

  always_ff @(posedge clk or negedge rst_async_n) begin
    if (!rst_async_n) begin
      vld_p <= '0;
      en_p  <= '0;
      for (int s = 0; s < IN_STAGES; s++) begin
        data_i_p[s] <= '0;
        data_q_p[s] <= '0;
      end
    end else begin
      vld_p[0] <= valid_in;
      en_p[0]  <= i_enable;
      if (valid_in) begin
        data_i_p[0] <= lane_i;
        data_q_p[0] <= lane_q;
      end
      for (int s = 1; s < IN_STAGES; s++) begin
        vld_p[s] <= vld_p[s-1];
        en_p[s]  <= en_p[s-1];
        if (vld_p[s-1]) begin
          data_i_p[s] <= data_i_p[s-1];
          data_q_p[s] <= data_q_p[s-1];
        end
      end
    end
  end

  assign o_core_valid  = vld_p[IN_STAGES-1];
  assign o_core_data_i = data_i_p[IN_STAGES-1];
  assign o_core_data_q = data_q_p[IN_STAGES-1];
  assign o_core_enable = en_p[IN_STAGES-1] && (state == IDLE);
  assign o_cfg_busy    = (state != IDLE);

  // Config FSM: drain the input pipe, then wait out the current core latency
  logic             pipe_empty, drain_done;
  logic [LAT_W-1:0] drain_cnt;
  assign pipe_empty = (vld_p == '0);
  assign drain_done = pipe_empty &&
                      (({1'b0, drain_cnt} + {1'b0, LAT_ONE}) >= {1'b0, o_core_static_pipe_lat});

  always_ff @(posedge clk or negedge rst_async_n) begin
    if (!rst_async_n) state <= IDLE;
    else              state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (i_cfg_update) state_nxt = DRAIN;
      DRAIN:   if (drain_done)   state_nxt = APPLY;
      APPLY:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_async_n) begin
    if (!rst_async_n) begin
      drain_cnt <= '0;
    end else if (state != DRAIN) begin
      drain_cnt <= '0;
    end else if (pipe_empty && !drain_done) begin
      drain_cnt <= drain_cnt + LAT_ONE;
    end
  end

  logic             pend_sub;
  logic [LAT_W-1:0] pend_lat;
  logic [CW-1:0]    pend_coef;

  always_ff @(posedge clk or negedge rst_async_n) begin
    if (!rst_async_n) begin
      pend_sub               <= 1'b0;
      pend_lat               <= '0;
      pend_coef              <= '0;
      o_core_subsampling     <= 1'b0;
      o_core_static_pipe_lat <= '0;
      o_core_static_coef     <= '0;
    end else begin
      if (state == IDLE && i_cfg_update) begin
        pend_sub  <= i_subsampling;
        pend_lat  <= i_static_pipe_lat;
        pend_coef <= i_static_coef;
      end
      if (state == APPLY) begin
        o_core_subsampling     <= pend_sub;
        o_core_static_pipe_lat <= pend_lat;
        o_core_static_coef     <= pend_coef;
      end
    end
  end

  // Latency watchdog: counts cycles since the block that armed it left the shell
  logic            wd_out, wd_fire;
  logic [WD_W-1:0] wd_cnt, wd_nxt, wd_limit;
  assign wd_limit = WD_W'(o_core_static_pipe_lat) + WD_W'(TO_MARGIN);
  assign wd_nxt   = wd_cnt + WD_ONE;
  assign wd_fire  = o_core_enable && !i_core_fo_valid &&
                    ((!wd_out && o_core_valid && (wd_limit == WD_ONE)) ||
                     (wd_out && (wd_cnt < wd_limit) && (wd_nxt == wd_limit)));

  always_ff @(posedge clk or negedge rst_async_n) begin
    if (!rst_async_n) begin
      wd_out <= 1'b0;
      wd_cnt <= '0;
    end else if (!o_core_enable || i_core_fo_valid) begin
      wd_out <= 1'b0;
      wd_cnt <= '0;
    end else if (!wd_out) begin
      if (o_core_valid) begin
        wd_out <= 1'b1;
        wd_cnt <= WD_ONE;
      end
    end else if (wd_cnt < wd_limit) begin
      wd_cnt <= wd_nxt;
    end
  end

  // Show-ahead result FIFO; pointers carry one wrap bit
  logic [NBW_OUT-1:0] mem [OUT_DEPTH];
  logic [AW:0]        wr_ptr, rd_ptr;
  logic               full, push, pop, wr_en, ovf_evt;

  assign o_fifo_level = wr_ptr - rd_ptr;
  assign full         = (o_fifo_level == (AW+1)'(OUT_DEPTH));
  assign o_fo_valid   = (o_fifo_level != '0);
  assign o_fo_value   = mem[rd_ptr[AW-1:0]];
  assign push         = i_core_fo_valid;
  assign pop          = o_fo_valid && i_fo_ready;
  assign wr_en        = push && (!full || pop);
  assign ovf_evt      = push && full && !pop;

  always_ff @(posedge clk or negedge rst_async_n) begin
    if (!rst_async_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int d = 0; d < OUT_DEPTH; d++) mem[d] <= '0;
    end else begin
      if (wr_en) begin
        mem[wr_ptr[AW-1:0]] <= i_core_fo_value;
        wr_ptr              <= wr_ptr + PTR_ONE;
      end
      if (pop) rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // Sticky status: a set event outranks a clear in the same cycle
  always_ff @(posedge clk or negedge rst_async_n) begin
    if (!rst_async_n) begin
      o_drop     <= 1'b0;
      o_overflow <= 1'b0;
      o_timeout  <= 1'b0;
    end else begin
      if (i_status_clr) begin
        o_drop     <= 1'b0;
        o_overflow <= 1'b0;
        o_timeout  <= 1'b0;
      end
      if (drop_evt) o_drop     <= 1'b1;
      if (ovf_evt)  o_overflow <= 1'b1;
      if (wd_fire)  o_timeout  <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fe_io_shell.sv
// Bench for fe_io_shell: pipeline vectors, config drain, watchdog, FIFO table and reset.
module tb_fe_io_shell;
  localparam int NBW_IN = 9, FE_NS_IN = 64, FE_NS_FIR = 5, NBW_OUT = 15, LAT_W = 10;
  localparam int DW = FE_NS_IN*NBW_IN, CW = FE_NS_FIR*NBW_IN;

  logic clk, rst_async_n;
  logic i_valid, i_enable, i_cfg_update, i_subsampling, i_status_clr;
  logic [DW-1:0] i_data_i, i_data_q, o_core_data_i, o_core_data_q;
  logic [LAT_W-1:0] i_static_pipe_lat, o_core_static_pipe_lat;
  logic [CW-1:0] i_static_coef, o_core_static_coef;
  logic o_core_valid, o_core_enable, o_core_subsampling;
  logic i_core_fo_valid, o_fo_valid, i_fo_ready;
  logic [NBW_OUT-1:0] i_core_fo_value, o_fo_value;
  logic o_cfg_busy, o_drop, o_overflow, o_timeout;
  logic [2:0] o_fifo_level;

  fe_io_shell #(.NBW_IN(NBW_IN), .FE_NS_IN(FE_NS_IN), .FE_NS_FIR(FE_NS_FIR), .NBW_OUT(NBW_OUT),
                .LAT_W(LAT_W), .IN_STAGES(2), .OUT_DEPTH(4), .TO_MARGIN(16), .REVERSE_LANES(1)) dut (
    .clk(clk), .rst_async_n(rst_async_n), .i_valid(i_valid), .i_enable(i_enable),
    .i_data_i(i_data_i), .i_data_q(i_data_q), .i_cfg_update(i_cfg_update),
    .i_subsampling(i_subsampling), .i_static_pipe_lat(i_static_pipe_lat),
    .i_static_coef(i_static_coef), .i_status_clr(i_status_clr),
    .o_core_valid(o_core_valid), .o_core_enable(o_core_enable),
    .o_core_data_i(o_core_data_i), .o_core_data_q(o_core_data_q),
    .o_core_subsampling(o_core_subsampling), .o_core_static_pipe_lat(o_core_static_pipe_lat),
    .o_core_static_coef(o_core_static_coef), .i_core_fo_valid(i_core_fo_valid),
    .i_core_fo_value(i_core_fo_value), .o_fo_valid(o_fo_valid), .o_fo_value(o_fo_value),
    .i_fo_ready(i_fo_ready), .o_cfg_busy(o_cfg_busy), .o_drop(o_drop),
    .o_overflow(o_overflow), .o_timeout(o_timeout), .o_fifo_level(o_fifo_level));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0, errors = 0;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [8:0] l0, l63, q7;
    logic       vld;
    logic [8:0] e_l0, e_l63, e_q56;
  } pipe_vec_t;

  typedef struct {
    logic        v;
    logic [14:0] val;
    logic        rdy, clr;
    logic [2:0]  lvl;
    logic        ovf, keep;
  } fifo_vec_t;

  typedef struct {
    logic [8:0] l0, l63, q56;
    int         cyc;
  } core_exp_t;

  core_exp_t   csb[$];
  logic [14:0] fsb[$];
  logic [8:0]  hold_l0 = '0;
  bit          hold_en = 0;
  core_exp_t   ce;

  // Core-side scoreboard: every o_core_valid must match the oldest expected block
  always @(negedge clk) begin
    if (rst_async_n) begin
      if (o_core_valid) begin
        if (csb.size() == 0) chk("core_valid_unexpected", o_core_valid, 1'b0);
        else begin
          ce = csb.pop_front();
          chk("core_lane0_i", o_core_data_i[0 +: 9], ce.l0);
          chk("core_lane63_i", o_core_data_i[63*9 +: 9], ce.l63);
          chk("core_lane56_q", o_core_data_q[56*9 +: 9], ce.q56);
          chk("core_latency", cyc, ce.cyc);
          hold_l0 = ce.l0;
        end
      end else if (hold_en) begin
        chk("core_hold", o_core_data_i[0 +: 9], hold_l0);
      end
    end
  end

  always @(negedge clk) begin
    if (rst_async_n && o_fo_valid && i_fo_ready) begin
      if (fsb.size() == 0) chk("fifo_unexpected", o_fo_valid, 1'b0);
      else chk("fifo_data", o_fo_value, fsb.pop_front());
    end
  end

  task automatic drive_block(input logic [8:0] l0, input logic [8:0] l63, input logic [8:0] q7,
                             input logic vld);
    core_exp_t e;
    i_data_i = '0;
    i_data_q = '0;
    i_data_i[0 +: 9]    = l0;
    i_data_i[63*9 +: 9] = l63;
    i_data_q[7*9 +: 9]  = q7;
    i_valid = vld;
    if (vld) begin
      e.l0 = l63; e.l63 = l0; e.q56 = q7; e.cyc = cyc + 2;
      csb.push_back(e);
    end
  endtask

  task automatic do_cfg(input logic sub, input logic [LAT_W-1:0] lat, input logic [CW-1:0] coef);
    int n;
    i_subsampling = sub; i_static_pipe_lat = lat; i_static_coef = coef;
    i_cfg_update = 1'b1;
    tick();
    i_cfg_update = 1'b0;
    n = 0;
    while (o_cfg_busy && n < 200) begin
      tick();
      n++;
    end
    chk("cfg_done", o_cfg_busy, 1'b0);
  endtask

  pipe_vec_t pv[6];
  fifo_vec_t fv[18];

  initial begin
    int n, k;
    pv[0] = '{9'h001, 9'h1FF, 9'h0AA, 1'b1, 9'h1FF, 9'h001, 9'h0AA};
    pv[1] = '{9'h055, 9'h0AA, 9'h123, 1'b0, 9'h000, 9'h000, 9'h000};
    pv[2] = '{9'h100, 9'h0FF, 9'h1C3, 1'b1, 9'h0FF, 9'h100, 9'h1C3};
    pv[3] = '{9'h1FF, 9'h000, 9'h000, 1'b1, 9'h000, 9'h1FF, 9'h000};
    pv[4] = '{9'h0F0, 9'h00F, 9'h1AB, 1'b0, 9'h000, 9'h000, 9'h000};
    pv[5] = '{9'h033, 9'h1CC, 9'h04E, 1'b1, 9'h1CC, 9'h033, 9'h04E};
    //          v    val      rdy   clr   lvl   ovf   keep
    fv[0]  = '{1'b1, 15'h01, 1'b0, 1'b0, 3'd1, 1'b0, 1'b1};
    fv[1]  = '{1'b1, 15'h02, 1'b0, 1'b0, 3'd2, 1'b0, 1'b1};
    fv[2]  = '{1'b1, 15'h03, 1'b0, 1'b0, 3'd3, 1'b0, 1'b1};
    fv[3]  = '{1'b1, 15'h04, 1'b0, 1'b0, 3'd4, 1'b0, 1'b1};
    fv[4]  = '{1'b1, 15'h05, 1'b0, 1'b0, 3'd4, 1'b1, 1'b0};
    fv[5]  = '{1'b1, 15'h1F, 1'b0, 1'b1, 3'd4, 1'b1, 1'b0};
    fv[6]  = '{1'b0, 15'h00, 1'b0, 1'b1, 3'd4, 1'b0, 1'b0};
    fv[7]  = '{1'b1, 15'h06, 1'b1, 1'b0, 3'd4, 1'b0, 1'b1};
    fv[8]  = '{1'b0, 15'h00, 1'b1, 1'b0, 3'd3, 1'b0, 1'b0};
    fv[9]  = '{1'b0, 15'h00, 1'b1, 1'b0, 3'd2, 1'b0, 1'b0};
    fv[10] = '{1'b1, 15'h07, 1'b1, 1'b0, 3'd2, 1'b0, 1'b1};
    fv[11] = '{1'b0, 15'h00, 1'b1, 1'b0, 3'd1, 1'b0, 1'b0};
    fv[12] = '{1'b0, 15'h00, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0};
    fv[13] = '{1'b0, 15'h00, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0};
    fv[14] = '{1'b1, 15'h08, 1'b0, 1'b0, 3'd1, 1'b0, 1'b1};
    fv[15] = '{1'b1, 15'h09, 1'b1, 1'b1, 3'd1, 1'b0, 1'b1};
    fv[16] = '{1'b0, 15'h00, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0};
    fv[17] = '{1'b0, 15'h00, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0};

    rst_async_n = 1'b0;
    i_valid = 0; i_enable = 0; i_cfg_update = 0; i_subsampling = 0; i_status_clr = 0;
    i_data_i = '0; i_data_q = '0; i_static_pipe_lat = '0; i_static_coef = '0;
    i_core_fo_valid = 0; i_core_fo_value = '0; i_fo_ready = 0;
    repeat (3) tick();
    chk("rst_core_valid", o_core_valid, 1'b0);
    chk("rst_core_enable", o_core_enable, 1'b0);
    chk("rst_busy", o_cfg_busy, 1'b0);
    chk("rst_flags", {o_drop, o_overflow, o_timeout}, 3'b000);
    chk("rst_level", o_fifo_level, 3'd0);
    chk("rst_fo_valid", o_fo_valid, 1'b0);
    chk("rst_lat", o_core_static_pipe_lat, 10'd0);
    chk("rst_data_zero", (o_core_data_i == '0) && (o_core_data_q == '0), 1'b1);
    rst_async_n = 1'b1;
    i_enable = 1'b1;
    tick();
    hold_en = 1;

    do_cfg(1'b1, 10'd20, 45'h1A5A5A5A5A5);
    chk("cfg_a_lat", o_core_static_pipe_lat, 10'd20);
    chk("cfg_a_sub", o_core_subsampling, 1'b1);
    chk("cfg_a_coef", o_core_static_coef, 45'h1A5A5A5A5A5);
    chk("enable_idle", o_core_enable, 1'b1);

    for (int r = 0; r < 6; r++) begin
      drive_block(pv[r].l0, pv[r].l63, pv[r].q7, pv[r].vld);
      tick();
    end
    i_valid = 1'b0;
    repeat (4) tick();
    chk("pipe_sb_empty", csb.size(), 0);

    // Config change with one block still in flight
    drive_block(9'h011, 9'h122, 9'h133, 1'b1);
    tick();
    i_valid = 1'b0;
    i_subsampling = 1'b0; i_static_pipe_lat = 10'd30; i_static_coef = 45'h0123456789AB;
    i_cfg_update = 1'b1;
    tick();
    i_cfg_update = 1'b0;
    n = 0;
    while (o_cfg_busy && n < 100) begin
      chk("enable_low_busy", o_core_enable, 1'b0);
      case (n)
        2: begin i_data_i = '1; i_valid = 1'b1; end
        3: begin i_valid = 1'b0; chk("drop_set", o_drop, 1'b1); i_status_clr = 1'b1; end
        4: begin chk("drop_clr", o_drop, 1'b0); i_valid = 1'b1; end
        5: begin i_valid = 1'b0; i_status_clr = 1'b0; chk("drop_set_wins", o_drop, 1'b1); end
        6: i_status_clr = 1'b1;
        7: begin i_status_clr = 1'b0; chk("drop_clr2", o_drop, 1'b0); end
        default: ;
      endcase
      tick();
      n++;
    end
    chk("busy_cycles", n, 22);
    chk("cfg_b_lat", o_core_static_pipe_lat, 10'd30);
    chk("cfg_b_sub", o_core_subsampling, 1'b0);
    chk("cfg_b_coef", o_core_static_coef, 45'h0123456789AB);
    chk("enable_back", o_core_enable, 1'b1);
    chk("drain_sb_empty", csb.size(), 0);

    // Watchdog with pipe_lat 8 and margin 16
    do_cfg(1'b0, 10'd8, 45'h0);
    i_fo_ready = 1'b1;
    drive_block(9'h005, 9'h006, 9'h007, 1'b1);
    k = cyc;
    tick();
    i_valid = 1'b0;
    while (!o_timeout && (cyc - k) < 60) tick();
    chk("timeout_cycle", cyc - k, 26);
    i_status_clr = 1'b1;
    tick();
    i_status_clr = 1'b0;
    chk("timeout_clr", o_timeout, 1'b0);
    i_core_fo_valid = 1'b1; i_core_fo_value = 15'h77; fsb.push_back(15'h77);
    tick();
    i_core_fo_valid = 1'b0;
    drive_block(9'h015, 9'h016, 9'h017, 1'b1);
    tick();
    i_valid = 1'b0;
    repeat (10) tick();
    i_core_fo_valid = 1'b1; i_core_fo_value = 15'h78; fsb.push_back(15'h78);
    tick();
    i_core_fo_valid = 1'b0;
    repeat (30) tick();
    chk("timeout_cleared_by_result", o_timeout, 1'b0);
    chk("wd_fifo_drained", fsb.size(), 0);

    // FIFO table
    for (int r = 0; r < 18; r++) begin
      i_core_fo_valid = fv[r].v; i_core_fo_value = fv[r].val;
      i_fo_ready = fv[r].rdy; i_status_clr = fv[r].clr;
      if (fv[r].keep) fsb.push_back(fv[r].val);
      if (r == 0) begin
        #2;
        chk("fifo_no_bypass", o_fo_valid, 1'b0);
      end
      tick();
      chk($sformatf("fifo_level_r%0d", r), o_fifo_level, fv[r].lvl);
      chk($sformatf("fifo_ovf_r%0d", r), o_overflow, fv[r].ovf);
    end
    i_core_fo_valid = 1'b0; i_status_clr = 1'b0;
    chk("fifo_sb_empty", fsb.size(), 0);

    // Reset pulse in the middle of a drain
    i_core_fo_valid = 1'b1; i_core_fo_value = 15'h55;
    tick();
    i_core_fo_valid = 1'b0;
    i_cfg_update = 1'b1; i_static_pipe_lat = 10'd40;
    tick();
    i_cfg_update = 1'b0;
    i_data_i = '1; i_valid = 1'b1;
    tick();
    i_valid = 1'b0;
    tick();
    chk("pre_rst_busy", o_cfg_busy, 1'b1);
    chk("pre_rst_drop", o_drop, 1'b1);
    chk("pre_rst_level", o_fifo_level, 3'd1);
    #3;
    rst_async_n = 1'b0;
    hold_l0 = '0;
    #1;
    chk("mid_rst_busy", o_cfg_busy, 1'b0);
    chk("mid_rst_flags", {o_drop, o_overflow, o_timeout}, 3'b000);
    chk("mid_rst_level", o_fifo_level, 3'd0);
    chk("mid_rst_fo_valid", o_fo_valid, 1'b0);
    chk("mid_rst_lat", o_core_static_pipe_lat, 10'd0);
    chk("mid_rst_enable", o_core_enable, 1'b0);
    tick();
    rst_async_n = 1'b1;
    repeat (3) tick();
    chk("post_rst_idle", o_cfg_busy, 1'b0);
    chk("post_rst_enable", o_core_enable, 1'b1);
    chk("post_rst_lat", o_core_static_pipe_lat, 10'd0);
    chk("final_core_sb_empty", csb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, checks %0d errors %0d", checks, errors);
    $fatal(1);
  end
endmodule
